// File: rtl/axi4_lite_strobe_regfile.sv
// AXI4-Lite register file with byte strobes, base-address decode, a user-side update port
// and a mirror of committed host writes.
module axi4_lite_strobe_regfile #(
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  localparam int         STRB_W     = DATA_WIDTH / 8,
  localparam int         LSB        = $clog2(STRB_W),
  localparam int         IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           awaddr,
  input  logic [2:0]            awprot,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [31:0]           araddr,
  input  logic [2:0]            arprot,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic                  user_ready,
  output logic                  write_en,
  output logic [IDX_W-1:0]      write_idx,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [IDX_W-1:0]      update_idx,
  input  logic [DATA_WIDTH-1:0] update_data,
  input  logic                  update_valid,
  output logic [1:0]            dbg_wr_state,
  output logic                  dbg_rd_state
);

  localparam logic [32:0] SPAN = 33'(DEPTH * STRB_W);

  typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return {1'b0, off} < SPAN;
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return off[LSB +: IDX_W];
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  w_state_t              w_state_q, w_state_d;
  r_state_t              r_state_q, r_state_d;
  logic [31:0]           aw_addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  write_en_q;
  logic [IDX_W-1:0]      write_idx_q;
  logic [DATA_WIDTH-1:0] write_data_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  aw_hs, w_hs, ar_hs, commit, c_ok;
  logic [31:0]           c_addr;
  logic [IDX_W-1:0]      c_idx;
  logic [DATA_WIDTH-1:0] c_data, merged;
  logic [STRB_W-1:0]     c_strb;

  // Every channel transfers on a cycle where both valid and ready are high; valid never waits on ready.
  assign awready = !rst && user_ready && (w_state_q == W_IDLE || w_state_q == W_WAIT_ADDR);
  assign wready  = !rst && user_ready && (w_state_q == W_IDLE || w_state_q == W_WAIT_DATA);
  assign arready = !rst && (r_state_q == R_IDLE);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ar_hs   = arvalid && arready;

  // A payload arriving on the commit edge is used directly; otherwise the captured copy.
  assign c_addr = aw_hs ? awaddr : aw_addr_q;
  assign c_data = w_hs ? wdata : wdata_q;
  assign c_strb = w_hs ? wstrb : wstrb_q;
  assign c_ok   = addr_ok(c_addr);
  assign c_idx  = addr_idx(c_addr);
  assign commit = (w_state_d == W_RESP) && (w_state_q != W_RESP);

  always_comb begin
    merged = mem_q[c_idx];
    for (int b = 0; b < STRB_W; b++) begin
      if (c_strb[b]) merged[b*8 +: 8] = c_data[b*8 +: 8];
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) w_state_d = W_RESP;
        else if (aw_hs)    w_state_d = W_WAIT_DATA;
        else if (w_hs)     w_state_d = W_WAIT_ADDR;
      end
      W_WAIT_DATA: if (w_hs) w_state_d = W_RESP;
      W_WAIT_ADDR: if (aw_hs) w_state_d = W_RESP;
      W_RESP:      if (bready) w_state_d = W_IDLE;
      default:     w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q    <= W_IDLE;
      aw_addr_q    <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= 2'b00;
      write_en_q   <= 1'b0;
      write_idx_q  <= '0;
      write_data_q <= '0;
    end else begin
      w_state_q  <= w_state_d;
      write_en_q <= commit && c_ok;
      if (aw_hs) aw_addr_q <= awaddr;
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (commit && c_ok) begin
        write_idx_q  <= c_idx;
        write_data_q <= merged;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= c_ok ? 2'b00 : 2'b10;
      end else if (bvalid_q && bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rresp_q  <= addr_ok(araddr) ? 2'b00 : 2'b10;
        rdata_q  <= addr_ok(araddr) ? mem_q[addr_idx(araddr)] : '0;
      end else if (rvalid_q && rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Storage has no reset; the user update is written last so it wins a same-index collision.
  always_ff @(posedge clk) begin
    if (commit && c_ok) mem_q[c_idx] <= merged;
    if (update_valid) mem_q[update_idx] <= update_data;
  end

  logic unused_prot;
  assign unused_prot = ^{awprot, arprot};

  assign bvalid       = bvalid_q;
  assign bresp        = bresp_q;
  assign rvalid       = rvalid_q;
  assign rresp        = rresp_q;
  assign rdata        = rdata_q;
  assign write_en     = write_en_q;
  assign write_idx    = write_idx_q;
  assign write_data   = write_data_q;
  assign dbg_wr_state = w_state_q;
  assign dbg_rd_state = r_state_q;

endmodule

// File: tb/tb_axi4_lite_strobe_regfile.sv
// Directed bench for axi4_lite_strobe_regfile: a 32-bit instance for the main flows and a
// 64-bit instance for mid-transaction reset and upper-byte strobes.
module tb_axi4_lite_strobe_regfile;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // 32-bit instance signals
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata, write_data, update_data = '0;
  logic [3:0]  wstrb = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        user_ready = 1, update_valid = 0;
  logic        awready, wready, bvalid, arready, rvalid, write_en, dbg_rd;
  logic [1:0]  bresp, rresp, dbg_wr;
  logic [7:0]  write_idx, update_idx = '0;

  // 64-bit instance signals
  logic [31:0] d_awaddr = '0, d_araddr = '0;
  logic [63:0] d_wdata = '0, d_rdata, d_write_data, d_update_data = '0;
  logic [7:0]  d_wstrb = '0, d_write_idx, d_update_idx = '0;
  logic [2:0]  d_awprot = '0, d_arprot = '0;
  logic        d_awvalid = 0, d_wvalid = 0, d_bready = 0, d_arvalid = 0, d_rready = 0;
  logic        d_user_ready = 1, d_update_valid = 0;
  logic        d_awready, d_wready, d_bvalid, d_arready, d_rvalid, d_write_en, d_dbg_rd;
  logic [1:0]  d_bresp, d_rresp, d_dbg_wr;

  axi4_lite_strobe_regfile #(.DATA_WIDTH(32), .DEPTH(256), .BASE_ADDR(32'h0)) u32 (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .user_ready(user_ready), .write_en(write_en), .write_idx(write_idx), .write_data(write_data),
    .update_idx(update_idx), .update_data(update_data), .update_valid(update_valid),
    .dbg_wr_state(dbg_wr), .dbg_rd_state(dbg_rd)
  );

  axi4_lite_strobe_regfile #(.DATA_WIDTH(64), .DEPTH(256), .BASE_ADDR(32'h0)) u64 (
    .clk(clk), .rst(rst),
    .awaddr(d_awaddr), .awprot(d_awprot), .awvalid(d_awvalid), .awready(d_awready),
    .wdata(d_wdata), .wstrb(d_wstrb), .wvalid(d_wvalid), .wready(d_wready),
    .bresp(d_bresp), .bvalid(d_bvalid), .bready(d_bready),
    .araddr(d_araddr), .arprot(d_arprot), .arvalid(d_arvalid), .arready(d_arready),
    .rdata(d_rdata), .rresp(d_rresp), .rvalid(d_rvalid), .rready(d_rready),
    .user_ready(d_user_ready), .write_en(d_write_en), .write_idx(d_write_idx),
    .write_data(d_write_data), .update_idx(d_update_idx), .update_data(d_update_data),
    .update_valid(d_update_valid), .dbg_wr_state(d_dbg_wr), .dbg_rd_state(d_dbg_rd)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues AW and W together on the 32-bit instance; leaves B pending.
  task automatic wr_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
    step();
    awvalid = 0; wvalid = 0;
  endtask

  task automatic b_done();
    bready = 1;
    step();
    bready = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                    output logic v);
    araddr = a; arvalid = 1;
    step();
    arvalid = 0;
    d = rdata; r = rresp; v = rvalid;
    rready = 1;
    step();
    rready = 0;
  endtask

  logic [31:0] rd_d;
  logic [1:0]  rd_r;
  logic        rd_v;

  initial begin
    // Reset
    step();
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    step();
    rst = 0;
    #1;
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_write_en", write_en, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_write_idx", write_idx, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_awready_after", awready, 1);

    // Same-cycle AW/W full write
    wr_issue(32'h10, 32'hDEADBEEF, 4'hF);
    chk("w1_bvalid", bvalid, 1);
    chk("w1_bresp", bresp, 0);
    chk("w1_write_en", write_en, 1);
    chk("w1_write_idx", write_idx, 4);
    chk("w1_write_data", write_data, 32'hDEADBEEF);
    b_done();
    chk("w1_bvalid_clr", bvalid, 0);
    chk("w1_write_en_clr", write_en, 0);
    rd(32'h10, rd_d, rd_r, rd_v);
    chk("r1_rvalid", rd_v, 1);
    chk("r1_rdata", rd_d, 32'hDEADBEEF);
    chk("r1_rresp", rd_r, 0);
    chk("r1_rvalid_clr", rvalid, 0);

    // W three cycles ahead of AW, partial strobe
    wdata = 32'h00001234; wstrb = 4'h3; wvalid = 1;
    step();
    wvalid = 0;
    #1;
    chk("w2_state_wait_addr", dbg_wr, 2);
    chk("w2_wready_low", wready, 0);
    chk("w2_no_bvalid", bvalid, 0);
    step();
    step();
    awaddr = 32'h10; awvalid = 1;
    step();
    awvalid = 0;
    chk("w2_bvalid", bvalid, 1);
    chk("w2_write_en", write_en, 1);
    chk("w2_write_data", write_data, 32'hDEAD1234);
    b_done();
    rd(32'h10, rd_d, rd_r, rd_v);
    chk("r2_rdata", rd_d, 32'hDEAD1234);

    // Out-of-range write and read
    wr_issue(32'h0, 32'hA5A5A5A5, 4'hF);
    b_done();
    wr_issue(32'h400, 32'h11111111, 4'hF);
    chk("oor_bvalid", bvalid, 1);
    chk("oor_bresp", bresp, 2'b10);
    chk("oor_write_en", write_en, 0);
    b_done();
    rd(32'h0, rd_d, rd_r, rd_v);
    chk("oor_idx0_unchanged", rd_d, 32'hA5A5A5A5);
    rd(32'h400, rd_d, rd_r, rd_v);
    chk("oor_rresp", rd_r, 2'b10);
    chk("oor_rdata", rd_d, 0);

    // Zero strobe is an OKAY no-op
    wr_issue(32'h0, 32'hFFFFFFFF, 4'h0);
    chk("nostrb_bresp", bresp, 0);
    b_done();
    rd(32'h0, rd_d, rd_r, rd_v);
    chk("nostrb_rdata", rd_d, 32'hA5A5A5A5);

    // B backpressure
    wr_issue(32'h20, 32'h0BADCAFE, 4'hF);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_bvalid", bvalid, 1);
      chk("bp_awready", awready, 0);
      chk("bp_write_en", write_en, 0);
    end
    b_done();
    chk("bp_bvalid_clr", bvalid, 0);

    // R backpressure
    araddr = 32'h20; arvalid = 1;
    step();
    arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rbp_rvalid", rvalid, 1);
      chk("rbp_rdata", rdata, 32'h0BADCAFE);
      chk("rbp_arready", arready, 0);
    end
    rready = 1;
    step();
    rready = 0;
    chk("rbp_rvalid_clr", rvalid, 0);

    // Collision: AXI commit, user update and read of idx 4 on one edge
    awaddr = 32'h10; awvalid = 1; wdata = 32'h55555555; wstrb = 4'hF; wvalid = 1;
    update_idx = 8'd4; update_data = 32'hCAFEF00D; update_valid = 1;
    araddr = 32'h10; arvalid = 1;
    step();
    awvalid = 0; wvalid = 0; update_valid = 0; arvalid = 0;
    chk("col_write_en", write_en, 1);
    chk("col_write_data", write_data, 32'h55555555);
    chk("col_bresp", bresp, 0);
    chk("col_rvalid", rvalid, 1);
    chk("col_rdata_old", rdata, 32'hDEAD1234);
    bready = 1; rready = 1;
    step();
    bready = 0; rready = 0;
    rd(32'h10, rd_d, rd_r, rd_v);
    chk("col_readback", rd_d, 32'hCAFEF00D);

    // 64-bit instance: prime word at idx 1
    d_awaddr = 32'h8; d_awvalid = 1; d_wdata = 64'h0123456789ABCDEF; d_wstrb = 8'hFF;
    d_wvalid = 1;
    step();
    d_awvalid = 0; d_wvalid = 0;
    chk("d_prime_bvalid", d_bvalid, 1);
    chk("d_prime_write_idx", d_write_idx, 1);
    d_bready = 1;
    step();
    d_bready = 0;

    // Reset while waiting for data abandons the write
    d_awaddr = 32'h8; d_awvalid = 1;
    step();
    d_awvalid = 0;
    chk("d_state_wait_data", d_dbg_wr, 1);
    rst = 1;
    #1;
    chk("d_rst_awready", d_awready, 0);
    chk("d_rst_wready", d_wready, 0);
    step();
    step();
    rst = 0;
    #1;
    chk("d_rst_state_idle", d_dbg_wr, 0);
    chk("d_rst_bvalid", d_bvalid, 0);
    chk("d_rst_write_en", d_write_en, 0);
    d_wdata = 64'hFFFFFFFFFFFFFFFF; d_wstrb = 8'hFF; d_wvalid = 1;
    step();
    d_wvalid = 0;
    chk("d_w_only_wait_addr", d_dbg_wr, 2);
    chk("d_w_only_no_bvalid", d_bvalid, 0);
    rst = 1;
    step();
    rst = 0;
    d_araddr = 32'h8; d_arvalid = 1;
    step();
    d_arvalid = 0;
    chk("d_no_commit_rdata", d_rdata, 64'h0123456789ABCDEF);
    d_rready = 1;
    step();
    d_rready = 0;

    // Upper-half strobe on 64-bit word
    d_awaddr = 32'h8; d_awvalid = 1; d_wdata = 64'hAABBCCDDEEFF0011; d_wstrb = 8'hF0;
    d_wvalid = 1;
    step();
    d_awvalid = 0; d_wvalid = 0;
    chk("d_f0_bresp", d_bresp, 0);
    chk("d_f0_write_en", d_write_en, 1);
    chk("d_f0_write_data", d_write_data, 64'hAABBCCDD89ABCDEF);
    d_bready = 1;
    step();
    d_bready = 0;
    d_araddr = 32'h8; d_arvalid = 1;
    step();
    d_arvalid = 0;
    chk("d_f0_rdata", d_rdata, 64'hAABBCCDD89ABCDEF);
    chk("d_f0_rresp", d_rresp, 0);
    d_rready = 1;
    step();
    d_rready = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
